// File: rtl/imem_loader_pkg.sv
// Shared encodings for the instruction-memory boot loader.
// Holds the FSM state type and the stream framing constants.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word assembler.
// word_valid is high in the cycle the fourth byte is accepted; word is the completed word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_en) begin
      shift_q <= {shift_q[15:0], byte_in};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  // The incoming byte completes the word combinationally so the loader can register it on the same edge.
  assign word_valid = byte_en && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word       = {shift_q, byte_in};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes big-endian words to
// instruction memory from address 0, and releases the CPU reset once the program is in.
//
// state  | meaning
// HDR_HI | waiting for word-count high byte
// HDR_LO | waiting for word-count low byte, then range check
// DATA   | packing bytes and writing words
// DONE   | program loaded, CPU released
// ERR    | header rejected, CPU held in reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t            state;
  logic [7:0]        n_hi;
  logic [15:0]       n_words;
  logic [15:0]       words_left;
  logic [ADDR_W-1:0] word_idx;
  logic              accept;
  logic              word_valid;
  logic [31:0]       word;

  assign accept  = in_valid && in_ready;
  assign n_words = {n_hi, in_data};

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (state != DATA),
    .byte_en    (accept && (state == DATA)),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HDR_HI;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      n_hi       <= '0;
      words_left <= '0;
      word_idx   <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        HDR_HI: begin
          in_ready <= 1'b1;
          if (accept) begin
            n_hi  <= in_data;
            state <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (accept) begin
            // Full 16-bit count is range-checked; it is never truncated to ADDR_W.
            if ((n_words == 16'd0) || ({1'b0, n_words} > DEPTH_L)) begin
              state    <= ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              words_left <= n_words;
              word_idx   <= '0;
              state      <= DATA;
            end
          end
        end
        DATA: begin
          if (word_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_idx;
            imem_wdata <= word;
            word_idx   <= word_idx + 1'b1;
            words_left <= words_left - 16'd1;
            if (words_left == 16'd1) in_ready <= 1'b0;
          end else if (!in_ready) begin
            // in_ready only drops in DATA during the final write pulse.
            state     <= DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end
        end
        DONE: begin
          in_ready <= 1'b0;
        end
        default: begin
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
